frame_copy_engine: RTL

//   Streams one full 320x240 8-bit frame from the work buffer (mem3) into the display

---
 rtl/frame_copy_engine.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/frame_copy_engine.sv
// Purpose : streams one full frame from the work buffer (mem3) into the display buffer (mem2) at 1 pixel/clock.
// Latency : first write RD_LATENCY clocks after issue starts; done pulses FRAME_PIXELS+RD_LATENCY+1 clocks after start.
// Backpr. : none; both RAM ports are always ready, so the copy never stalls (abort is the only way to stop it early).
//
// Ports
//   clock        system clock
//   reset        async active-high reset, clears all state
//   start        1-cycle copy request, ignored while busy
//   abort        sync cancel of a running copy (no done pulse)
//   busy         high from the cycle after an accepted start until done/abort
//   done         1-cycle pulse in the cycle after the last write
//   src_rd_addr  mem3 read address
//   src_rd_data  mem3 read data, valid RD_LATENCY clocks after its address
//   dst_wr_addr  mem2 write address
//   dst_wr_data  mem2 write data
//   dst_wren     mem2 write enable, one pixel per high cycle
//   checksum     (only with COPY_CHECKSUM_EN) mod-2^16 sum of the pixels written by the current copy
//
// Build option: define COPY_CHECKSUM_EN to add the checksum output and its accumulator.

module frame_copy_engine #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 8,
    parameter int FRAME_PIXELS = 76800,
    parameter int RD_LATENCY   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] src_rd_addr,
    input  logic [DATA_W-1:0] src_rd_data,
    output logic [ADDR_W-1:0] dst_wr_addr,
    output logic [DATA_W-1:0] dst_wr_data,
    output logic              dst_wren
`ifdef COPY_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
    localparam int                TAIL      = RD_LATENCY - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] rd_ptr;

    // Read-tracking pipeline: one (valid, addr) entry per outstanding read,
    // aligned so that the tail entry matches the data on src_rd_data.
    logic [RD_LATENCY-1:0] pipe_vld;
    logic [ADDR_W-1:0]     pipe_addr [RD_LATENCY];

    logic load;       // start accepted this cycle
    logic issue;      // a read is issued this cycle
    logic flush;      // abort accepted this cycle
    logic done_nxt;
    logic last_write; // the final pixel of the frame is being written now

    //------------------------------------------------------------------
    // Control FSM
    //------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign last_write = dst_wren && (dst_wr_addr == LAST_ADDR);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        issue     = 1'b0;
        flush     = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                // abort has no meaning here, so start always wins
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    flush     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    issue = 1'b1;
                    if (rd_ptr == LAST_ADDR) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Only trailing entries are valid here, so the write of the last
                // address is also the moment the pipeline empties.
                if (abort) begin
                    flush     = 1'b1;
                    state_nxt = IDLE;
                end else if (last_write) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Read pointer and done pulse
    //------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            done   <= 1'b0;
        end else begin
            done <= done_nxt;
            if (load) begin
                rd_ptr <= '0;
            end else if (issue && (rd_ptr != LAST_ADDR)) begin
                // Holds at the last address rather than wrapping
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
        end
    end

    //------------------------------------------------------------------
    // Read-tracking pipeline
    //------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_addr[i] <= '0;
            end
        end else begin
            // The write in the abort cycle itself still lands; everything
            // still in flight behind it is discarded.
            if (load || flush) begin
                pipe_vld <= '0;
            end else begin
                pipe_vld[0] <= issue;
                for (int i = 1; i < RD_LATENCY; i++) begin
                    pipe_vld[i] <= pipe_vld[i-1];
                end
            end
            pipe_addr[0] <= rd_ptr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    assign busy        = (state != IDLE);
    assign src_rd_addr = rd_ptr;
    assign dst_wren    = pipe_vld[TAIL];
    assign dst_wr_addr = pipe_addr[TAIL];
    // Gate the data so the write bus reads zero whenever no write is in progress
    assign dst_wr_data = dst_wren ? src_rd_data : '0;

`ifdef COPY_CHECKSUM_EN
    //------------------------------------------------------------------
    // Checksum of written pixels; frozen between done and the next start
    //------------------------------------------------------------------
    logic [15:0] sum_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (load) begin
            sum_q <= '0;
        end else if (dst_wren) begin
            sum_q <= sum_q + 16'(dst_wr_data);
        end
    end

    assign checksum = sum_q;
`endif

endmodule
